// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the SRAM port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_CNT_W   = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - data-first priority pick with a fetch anti-starvation counter
module mem_arb_grant
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic d_valid,
  input  logic accept_en,
  output logic grant_i,
  output logic grant_d
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;
  logic             fetch_starved;

  always_comb begin
    fetch_starved = i_valid && (starve_q == CNT_MAX);
    grant_d       = accept_en && d_valid && !fetch_starved;
    grant_i       = accept_en && i_valid && !grant_d;

    // Counts data wins only while a fetch is actually waiting.
    starve_d = starve_q;
    if (!i_valid || grant_i) begin
      starve_d = '0;
    end else if (grant_d && (starve_q != CNT_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one SRAM port between instruction fetch and data requesters
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_W-1:0]     i_req_addr,
  output logic                  i_rsp_valid,
  output logic [31:0]           i_rsp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_we,
  input  logic [ADDR_W-1:0]     d_req_addr,
  input  logic [DATA_W-1:0]     d_req_wdata,
  input  logic [DATA_W/8-1:0]   d_req_wstrb,
  output logic                  d_rsp_valid,
  output logic [DATA_W-1:0]     d_rsp_data,
  output logic                  mem_e,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LAT    = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                          (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(LAT);

  arb_state_e           state_q, state_d;
  logic [LAT_CNT_W-1:0] lat_q, lat_d;
  logic                 id_q, id_d;
  logic                 sel_hi_q, sel_hi_d;
  logic                 we_q, we_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 i_rsp_valid_q, i_rsp_valid_d;
  logic                 d_rsp_valid_q, d_rsp_valid_d;

  logic accept_en;
  logic grant_i;
  logic grant_d;
  logic granted;

  // Readys must read 0 while reset is held, so the async reset also gates accept.
  assign accept_en = rst && ((state_q == IDLE) || (state_q == RESP));
  assign granted   = grant_i || grant_d;

  mem_arb_grant #(
    .STARVE_MAX(STARVE_MAX)
  ) u_grant (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_req_valid),
    .d_valid  (d_req_valid),
    .accept_en(accept_en),
    .grant_i  (grant_i),
    .grant_d  (grant_d)
  );

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  always_comb begin
    mem_e     = granted;
    mem_we    = grant_d && d_req_we;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (grant_d) begin
      mem_addr  = d_req_addr;
      mem_wdata = d_req_wdata;
      mem_wstrb = d_req_wstrb;
    end else if (grant_i) begin
      mem_addr  = i_req_addr;
    end
  end

  always_comb begin
    state_d       = state_q;
    lat_d         = lat_q;
    id_d          = id_q;
    sel_hi_d      = sel_hi_q;
    we_d          = we_q;
    rdata_d       = rdata_q;
    i_rsp_valid_d = 1'b0;
    d_rsp_valid_d = 1'b0;

    case (state_q)
      WAIT: begin
        if (lat_q == LAT_LAST) begin
          rdata_d       = mem_rdata;
          lat_d         = '0;
          state_d       = RESP;
          i_rsp_valid_d = (id_q == REQ_I);
          d_rsp_valid_d = (id_q == REQ_D);
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A grant in RESP overrides the return to IDLE; the cycle after issue is latency cycle 1.
    if (granted) begin
      state_d  = WAIT;
      lat_d    = LAT_CNT_W'(1);
      id_d     = grant_d ? REQ_D : REQ_I;
      sel_hi_d = i_req_addr[2];
      we_d     = grant_d && d_req_we;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      lat_q         <= '0;
      id_q          <= REQ_I;
      sel_hi_q      <= 1'b0;
      we_q          <= 1'b0;
      rdata_q       <= '0;
      i_rsp_valid_q <= 1'b0;
      d_rsp_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lat_q         <= lat_d;
      id_q          <= id_d;
      sel_hi_q      <= sel_hi_d;
      we_q          <= we_d;
      rdata_q       <= rdata_d;
      i_rsp_valid_q <= i_rsp_valid_d;
      d_rsp_valid_q <= d_rsp_valid_d;
    end
  end

  assign i_rsp_valid = i_rsp_valid_q;
  assign d_rsp_valid = d_rsp_valid_q;

  always_comb begin
    i_rsp_data = '0;
    d_rsp_data = '0;
    if (i_rsp_valid_q) begin
      i_rsp_data = sel_hi_q ? rdata_q[DATA_W/2 +: 32] : rdata_q[0 +: 32];
    end
    if (d_rsp_valid_q && !we_q) begin
      d_rsp_data = rdata_q;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int LAT  = 3;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req_valid, i_req_ready, i_rsp_valid;
  logic [AW-1:0] i_req_addr;
  logic [31:0]   i_rsp_data;
  logic          d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata, d_rsp_data;
  logic [7:0]    d_req_wstrb;
  logic          mem_e, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [7:0]    mem_wstrb;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_e(mem_e), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [63:0] addr; logic [63:0] wdata; logic [7:0] wstrb; } dreq_t;
  typedef struct { logic is_d; logic [63:0] data; int due; } exp_t;

  logic [63:0] fq[$];
  dreq_t       dq[$];
  exp_t        exp_q[$];
  int          acc_cyc[$];
  logic [63:0] ref_mem[logic [60:0]];
  logic [63:0] sram[logic [60:0]];
  logic [63:0] dl[LAT];
  logic [63:0] rd_next;

  int    total = 0, bad = 0, cyc = 0, starve_m = 0, next_ok = 0, rsp_cnt = 0;
  bit    i_hs = 0, d_hs = 0, gappy = 0;
  string glog = "";
  logic [31:0] last_i;
  logic [63:0] last_d;
  logic        gi, gd;
  logic [63:0] word;
  exp_t        e;
  dreq_t       dr;

  function automatic logic [63:0] init_word(logic [60:0] k);
    return {k[31:0] ^ 32'h5A5A_0F0F, ~k[31:0]};
  endfunction
  function automatic logic [63:0] ref_rd(logic [60:0] k);
    return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
  endfunction
  function automatic logic [63:0] sram_rd(logic [60:0] k);
    return sram.exists(k) ? sram[k] : init_word(k);
  endfunction
  function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] wd, logic [7:0] st);
    logic [63:0] r = old;
    for (int b = 0; b < 8; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctrl"}, 64'({i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid, mem_e, mem_we}), 64'd0);
    chk({tag, "_mem_addr"}, mem_addr, 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({tag, "_mem_wstrb"}, 64'(mem_wstrb), 64'd0);
    chk({tag, "_i_rsp_data"}, 64'(i_rsp_data), 64'd0);
    chk({tag, "_d_rsp_data"}, d_rsp_data, 64'd0);
  endtask

  task automatic preload(input logic [63:0] addr, input logic [63:0] val);
    ref_mem[addr[63:3]] = val;
    sram[addr[63:3]]    = val;
  endtask

  task automatic drain(input string name, input int maxc);
    int n = 0;
    while ((fq.size() != 0 || dq.size() != 0 || i_req_valid || d_req_valid || exp_q.size() != 0)
           && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain_budget"}, 64'(n >= maxc), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor, reference model and scoreboard.
  initial forever begin
    @(negedge clk);
    cyc++;
    rd_next = {$urandom, $urandom};
    if (!rst) begin
      chk_reset("rst_hold");
    end else begin
      gd = (cyc >= next_ok) && d_req_valid && !(i_req_valid && starve_m == SMAX);
      gi = (cyc >= next_ok) && i_req_valid && !gd;
      chk("ready", 64'({i_req_ready, d_req_ready}), 64'({gi, gd}));
      chk("mem_e", 64'(mem_e), 64'(gi | gd));
      chk("mem_we", 64'(mem_we), 64'(gd && d_req_we));
      if (gi || gd) begin
        chk("mem_addr", mem_addr, gd ? d_req_addr : i_req_addr);
        chk("mem_wstrb", 64'(mem_wstrb), gd ? 64'(d_req_wstrb) : 64'd0);
        if (gd) chk("mem_wdata", mem_wdata, d_req_wdata);
      end

      if (i_rsp_valid || d_rsp_valid) begin
        rsp_cnt++;
        chk("rsp_onehot", 64'(i_rsp_valid & d_rsp_valid), 64'd0);
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'({i_rsp_valid, d_rsp_valid}), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_owner", 64'(d_rsp_valid), 64'(e.is_d));
          chk("rsp_cycle", 64'(cyc), 64'(e.due));
          chk("rsp_data", e.is_d ? d_rsp_data : 64'(i_rsp_data), e.data);
          if (i_rsp_valid) last_i = i_rsp_data;
          if (d_rsp_valid) last_d = d_rsp_data;
        end
      end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        chk("rsp_missing_cycle", 64'(cyc), 64'(e.due));
      end

      if (gd) begin
        if (d_req_we) begin
          ref_mem[d_req_addr[63:3]] = merge(ref_rd(d_req_addr[63:3]), d_req_wdata, d_req_wstrb);
          exp_q.push_back('{is_d: 1'b1, data: 64'd0, due: cyc + LAT + 1});
        end else begin
          exp_q.push_back('{is_d: 1'b1, data: ref_rd(d_req_addr[63:3]), due: cyc + LAT + 1});
        end
        next_ok = cyc + LAT + 1;
      end else if (gi) begin
        word = ref_rd(i_req_addr[63:3]);
        exp_q.push_back('{is_d: 1'b0, data: 64'(i_req_addr[2] ? word[63:32] : word[31:0]),
                          due: cyc + LAT + 1});
        next_ok = cyc + LAT + 1;
      end
      if (!i_req_valid || gi) starve_m = 0;
      else if (gd && starve_m < SMAX) starve_m++;

      if (d_req_valid && d_req_ready) begin glog = {glog, "D"}; acc_cyc.push_back(cyc); d_hs = 1; end
      if (i_req_valid && i_req_ready) begin glog = {glog, "I"}; i_hs = 1; end
    end

    if (mem_e) begin
      if (mem_we) sram[mem_addr[63:3]] = merge(sram_rd(mem_addr[63:3]), mem_wdata, mem_wstrb);
      else        rd_next = sram_rd(mem_addr[63:3]);
    end
  end

  // SRAM: data for an access issued in cycle T is visible during cycle T+LAT.
  initial begin
    for (int i = 0; i < LAT; i++) dl[i] = '0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = LAT - 1; i > 0; i--) dl[i] = dl[i-1];
      dl[0]     = rd_next;
      mem_rdata = dl[LAT-1];
    end
  end

  initial begin
    i_req_valid = 0; i_req_addr = '0;
    forever begin
      @(posedge clk); #1;
      if (i_hs) begin i_req_valid = 0; i_hs = 0; end
      if (!i_req_valid && fq.size() != 0 && (!gappy || $urandom_range(0, 3) != 0)) begin
        i_req_addr  = fq.pop_front();
        i_req_valid = 1;
      end
    end
  end

  initial begin
    d_req_valid = 0; d_req_we = 0; d_req_addr = '0; d_req_wdata = '0; d_req_wstrb = '0;
    forever begin
      @(posedge clk); #1;
      if (d_hs) begin d_req_valid = 0; d_hs = 0; end
      if (!d_req_valid && dq.size() != 0 && (!gappy || $urandom_range(0, 3) != 0)) begin
        dr          = dq.pop_front();
        d_req_we    = dr.we;
        d_req_addr  = dr.addr;
        d_req_wdata = dr.wdata;
        d_req_wstrb = dr.wstrb;
        d_req_valid = 1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rsp_before;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1;
    repeat (2) @(negedge clk);

    preload(64'h8000_0000, 64'h1111_2222_3333_4444);
    fq.push_back(64'h8000_0004);
    drain("fetch_single", 200);
    chk("fetch_single_data", 64'(last_i), 64'h1111_2222);

    dq.push_back('{1'b1, 64'h8000_1000, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF});
    dq.push_back('{1'b0, 64'h8000_1000, 64'd0, 8'h00});
    drain("store_load", 200);
    chk("load_after_store", last_d, 64'hDEAD_BEEF_CAFE_F00D);

    glog = "";
    for (int i = 0; i < 10; i++) dq.push_back('{1'b0, 64'h8000_4000 + 64'(i) * 64'd8, 64'd0, 8'h00});
    fq.push_back(64'h8000_5000);
    fq.push_back(64'h8000_5004);
    drain("contention", 500);
    total++;
    if (glog.substr(0, 9) != "DDDDIDDDDI") begin
      bad++;
      $display("FAIL contention_order: got %s expected DDDDIDDDDI", glog);
    end

    acc_cyc.delete();
    for (int i = 0; i < 5; i++) dq.push_back('{1'b0, 64'h8000_6000 + 64'(i) * 64'd8, 64'd0, 8'h00});
    drain("b2b", 300);
    chk("b2b_count", 64'(acc_cyc.size()), 64'd5);
    for (int i = 1; i < 5; i++) chk("b2b_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(LAT + 1));

    preload(64'h8000_2000, 64'hAAAA_0001_BBBB_0002);
    preload(64'h8000_2008, 64'hCCCC_0003_DDDD_0004);
    fq.push_back(64'h8000_2000);
    fq.push_back(64'h8000_2004);
    fq.push_back(64'h8000_2008);
    fq.push_back(64'h8000_200C);
    drain("fetch_stream", 300);
    chk("fetch_stream_last", 64'(last_i), 64'hCCCC_0003);

    gappy = 1;
    for (int i = 0; i < 60; i++) begin
      fq.push_back(64'h8000_3000 + 64'($urandom_range(0, 15)) * 64'd4);
      dq.push_back('{1'($urandom_range(0, 1)), 64'h8000_3000 + 64'($urandom_range(0, 7)) * 64'd8,
                     {$urandom, $urandom}, 8'($urandom)});
    end
    drain("random", 5000);
    gappy = 0;

    acc_cyc.delete();
    dq.push_back('{1'b0, 64'h8000_0008, 64'd0, 8'h00});
    n = 0;
    while (acc_cyc.size() == 0 && n < 50) begin @(negedge clk); n++; end
    chk("rst_load_accepted", 64'(acc_cyc.size()), 64'd1);
    @(posedge clk); #2 rst = 0;
    #1 chk_reset("rst_async");
    exp_q.delete();
    next_ok = 0; starve_m = 0; i_hs = 0; d_hs = 0;
    repeat (3) @(negedge clk);
    rsp_before = rsp_cnt;
    @(posedge clk); #2 rst = 1;
    repeat (LAT + 4) @(negedge clk);
    chk("no_rsp_after_reset", 64'(rsp_cnt - rsp_before), 64'd0);
    dq.push_back('{1'b0, 64'h8000_0010, 64'd0, 8'h00});
    drain("post_reset", 200);
    chk("post_reset_accepts", 64'(acc_cyc.size()), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one physical SRAM port between the core's instruction-fetch requester and data requester.
- Sits between the core's fetch/data interfaces and the post-MMU SRAM port, so the core can run against a single unified memory.
- Sequences each access: grant, issue, wait for fixed SRAM latency, capture, respond.
- Data requests have priority; an anti-starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 64, address width of requests and memory port.
- DATA_W, 64, memory data width; fetch returns DATA_W/2 bits.
- MEM_LAT, 1, cycles from mem_e to valid mem_rdata; legal range 1..4.
- STARVE_MAX, 4, maximum consecutive data grants while a fetch is pending.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- i_req_valid  in  1  fetch request.
- i_req_ready  out  1  fetch request accepted this cycle.
- i_req_addr  in  ADDR_W  fetch address; bit 2 selects word.
- i_rsp_valid  out  1  one-cycle fetch response pulse.
- i_rsp_data  out  32  fetched instruction.
- d_req_valid  in  1  data request.
- d_req_ready  out  1  data request accepted this cycle.
- d_req_we  in  1  1 = store, 0 = load.
- d_req_addr  in  ADDR_W  data address.
- d_req_wdata  in  DATA_W  store data.
- d_req_wstrb  in  DATA_W/8  byte strobes for store.
- d_rsp_valid  out  1  one-cycle data response/ack pulse.
- d_rsp_data  out  DATA_W  load data; 0 for stores.
- mem_e  out  1  SRAM access enable, one cycle per access.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_wstrb  out  DATA_W/8  SRAM byte strobes.
- mem_rdata  in  DATA_W  SRAM read data.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; latency counter = 0; starve counter = 0.
  - All outputs are 0: ready, rsp_valid, mem_e, mem_we, mem_addr, mem_wdata, mem_wstrb, rsp data.
  - Any in-flight access is dropped with no response.
- FSM states: IDLE, WAIT, RESP.
  - Accept is possible only in IDLE or RESP.
  - At most one ready is high per cycle.
  - A handshake is valid && ready in the same cycle.
- Grant rule when accepting:
  - Grant data if d_req_valid, unless i_req_valid and starve_cnt == STARVE_MAX.
  - Otherwise grant fetch if i_req_valid.
  - Grant is combinational from the valids and the current state.
- Handshake cycle T:
  - mem_e=1; mem_addr and mem_we/wdata/wstrb are driven combinationally from the granted request.
  - For fetch: mem_we=0 and wstrb=0.
  - Latch the granted-requester id, address bit 2 and we; go to WAIT.
  - When not accepting: mem_e=0 and mem_we=0.
- WAIT:
  - Counter counts MEM_LAT cycles.
  - At T+MEM_LAT, sample mem_rdata into the response register; go to RESP.
- RESP (cycle T+MEM_LAT+1):
  - Assert the owning rsp_valid for exactly one cycle.
  - i_rsp_data = addr_q[2] ? rdata_q[63:32] : rdata_q[31:0].
  - d_rsp_data = rdata_q for loads, 0 for stores.
  - A new request may be accepted this same cycle; else return to IDLE.
  - Back-to-back throughput: one access per MEM_LAT+1 cycles.
- Starve counter:
  - Increments on each data grant while i_req_valid=1, saturating at STARVE_MAX.
  - Clears on a fetch grant or on any cycle with i_req_valid=0.
- Simultaneous valids with starve_cnt < STARVE_MAX: data wins.
- Requesters must hold valid and payload stable until ready. Responses cannot be back-pressured.
- Fetch addr[1:0] is ignored, with no misalignment check. Data addr is passed unmodified; alignment is the requester's job.
- Request inputs sampled outside a handshake have no effect.

Decomposition:
- Shared package holds:
  - State enum {IDLE, WAIT, RESP}.
  - Requester id constants REQ_I=0 and REQ_D=1.
  - MEM_LAT legal-range constants.
- One sub-module, mem_arb_grant, holds the combinational priority pick plus the starve counter register. Inputs: valids, accept-enable. Outputs: grant_i, grant_d.
- The FSM, latency counter and response register stay in the top of the block.

Test Plan:
- Reset: hold rst=0 mid-WAIT of a load to 0x80000008 -> all outputs 0 at once; no d_rsp_valid after release; next request is accepted in IDLE.
- Single fetch, MEM_LAT=1: i_req addr=0x80000004, memory returns 0x1111_2222_3333_4444 -> mem_e at T, i_rsp_valid only at T+2, data 0x11112222.
- Store then load, same address 0x80001000:
  - Store wdata 0xDEADBEEF_CAFEF00D, wstrb 0xFF -> mem_we=1 at T and d_rsp_valid at T+2 with data 0.
  - Following load -> d_rsp_data 0xDEADBEEF_CAFEF00D.
- Contention: both valid continuously with STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I; never two readys in one cycle.
- Back-to-back, MEM_LAT=3: five data loads held valid -> accepts at T, T+4, T+8, ...; each d_rsp_valid is exactly one cycle, 4 cycles after its accept.
- Fetch-only streaming with d_req_valid=0 -> starve counter stays 0; fetches alternate word select correctly for addr 0x...0 and 0x...4.
